// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: taken decode, target generation, registered
// redirect and multi-cycle IF/ID flush. Optional counters behind `BRANCH_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            BrEq,
  input  logic            BrLT,
  output logic            BrUn,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if,
  output logic            flush_id,
  output logic            ex_squash,
  output logic            illegal_branch,
  output logic            misaligned_target,
  output logic [31:0]     perf_branch_cnt,
  output logic [31:0]     perf_taken_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [XLEN-1:0] JALR_MASK  = ~(XLEN'(1));

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            flush_q;
  logic            illegal_q;
  logic            misaligned_q;

  logic            resolve;
  logic            sel_jalr;
  logic            sel_jal;
  logic            sel_br;
  logic            br_cond;
  logic            br_legal;
  logic            taken;
  logic [XLEN-1:0] sum_pc;
  logic [XLEN-1:0] sum_rs1;
  logic [XLEN-1:0] target;
  logic            do_redirect;
  logic            do_misalign;
  logic            do_illegal;

  assign BrUn      = ex_funct3[1];
  assign ex_squash = ex_valid & (state_q == FLUSH);

  // Outcome and target decode for the instruction currently in EX.
  always_comb begin
    resolve  = ex_valid & ~ex_stall & (state_q == IDLE);
    sel_jalr = ex_is_jalr;
    sel_jal  = ex_is_jal & ~ex_is_jalr;
    sel_br   = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
    br_legal = (ex_funct3[2:1] != 2'b01);

    case (ex_funct3)
      3'b000:  br_cond = BrEq;
      3'b001:  br_cond = ~BrEq;
      3'b100:  br_cond = BrLT;
      3'b101:  br_cond = ~BrLT;
      3'b110:  br_cond = BrLT;
      3'b111:  br_cond = ~BrLT;
      default: br_cond = 1'b0;
    endcase

    sum_pc  = ex_pc + ex_imm;
    sum_rs1 = ex_rs1 + ex_imm;
    if (sel_jalr) begin
      target = sum_rs1 & JALR_MASK;
    end else begin
      target = sum_pc;
    end

    taken       = sel_jalr | sel_jal | (sel_br & br_cond);
    do_redirect = resolve & taken & ~target[1];
    do_misalign = resolve & taken & target[1];
    do_illegal  = resolve & sel_br & ~br_legal;
  end

  // Control FSM with registered redirect, flush and exception pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= 3'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      illegal_q        <= 1'b0;
      misaligned_q     <= 1'b0;
    end else begin
      redirect_valid_q <= do_redirect;
      illegal_q        <= do_illegal;
      misaligned_q     <= do_misalign;
      if (do_redirect) begin
        redirect_pc_q <= target;
      end else begin
        redirect_pc_q <= redirect_pc_q;
      end

      case (state_q)
        IDLE: begin
          if (do_redirect) begin
            state_q <= FLUSH;
            cnt_q   <= FLUSH_INIT;
            flush_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            cnt_q   <= cnt_q;
            flush_q <= 1'b0;
          end
        end
        FLUSH: begin
          // The last unstalled cycle drops flush on the following edge.
          if (ex_stall) begin
            state_q <= FLUSH;
            cnt_q   <= cnt_q;
            flush_q <= 1'b1;
          end else if (cnt_q <= 3'd1) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            flush_q <= 1'b0;
          end else begin
            state_q <= FLUSH;
            cnt_q   <= cnt_q - 3'd1;
            flush_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 3'd0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid    = redirect_valid_q;
  assign redirect_pc       = redirect_pc_q;
  assign flush_if          = flush_q;
  assign flush_id          = flush_q;
  assign illegal_branch    = illegal_q;
  assign misaligned_target = misaligned_q;

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_branch_cnt_q;
  logic [31:0] perf_taken_cnt_q;
  logic        count_br;
  logic        count_tk;

  assign count_br = resolve & sel_br & br_legal;
  assign count_tk = count_br & do_redirect;

  // Resolved-branch and taken-branch counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branch_cnt_q <= 32'd0;
      perf_taken_cnt_q  <= 32'd0;
    end else begin
      if (count_br) begin
        perf_branch_cnt_q <= perf_branch_cnt_q + 32'd1;
      end else begin
        perf_branch_cnt_q <= perf_branch_cnt_q;
      end
      if (count_tk) begin
        perf_taken_cnt_q <= perf_taken_cnt_q + 32'd1;
      end else begin
        perf_taken_cnt_q <= perf_taken_cnt_q;
      end
    end
  end

  assign perf_branch_cnt = perf_branch_cnt_q;
  assign perf_taken_cnt  = perf_taken_cnt_q;
`else
  assign perf_branch_cnt = 32'd0;
  assign perf_taken_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench for branch_resolve_unit plus directed multi-cycle sequences.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic        BrEq, BrLT;
  logic        BrUn, redirect_valid, flush_if, flush_id, ex_squash;
  logic        illegal_branch, misaligned_target;
  logic [31:0] redirect_pc, perf_branch_cnt, perf_taken_cnt;

  int n_vec = 0;
  int n_err = 0;

  branch_resolve_unit #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
    .ex_squash(ex_squash), .illegal_branch(illegal_branch),
    .misaligned_target(misaligned_target), .perf_branch_cnt(perf_branch_cnt),
    .perf_taken_cnt(perf_taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v, br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1;
    logic        eq, lt;
    logic        exp_rd;
    logic [31:0] exp_pc;
    logic        exp_ill, exp_mis;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic br, input logic jal,
                       input logic jalr, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input logic eq, input logic lt);
    ex_valid = v; ex_stall = st; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; BrEq = eq; BrLT = lt;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    //          name        v     br    jal   jalr  f3      pc            imm           rs1           eq    lt    rd    exp_pc        ill   mis
    vecs[0]  = '{"beq_t",    1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100,      32'h20,       32'h0,        1'b1, 1'b0, 1'b1, 32'h120,      1'b0, 1'b0};
    vecs[1]  = '{"beq_nt",   1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100,      32'h20,       32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{"bne_t",    1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'h200,      32'hFFFFFFF0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h1F0,      1'b0, 1'b0};
    vecs[3]  = '{"blt_t",    1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'h300,      32'h8,        32'h0,        1'b0, 1'b1, 1'b1, 32'h308,      1'b0, 1'b0};
    vecs[4]  = '{"bge_nt",   1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 32'h300,      32'h8,        32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{"bltu_nt",  1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'h300,      32'h8,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{"bgeu_t",   1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 32'h40,       32'h40,       32'h0,        1'b0, 1'b0, 1'b1, 32'h80,       1'b0, 1'b0};
    vecs[7]  = '{"ill_010",  1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h100,      32'h20,       32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[8]  = '{"ill_011",  1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 32'h100,      32'h20,       32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[9]  = '{"jalr_mis", 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0,        32'h4,        32'h203,      1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[10] = '{"jalr_ok",  1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0,        32'h4,        32'h201,      1'b0, 1'b0, 1'b1, 32'h204,      1'b0, 1'b0};
    vecs[11] = '{"jal_wrap", 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFFFFF0, 32'h20,       32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       1'b0, 1'b0};
    vecs[12] = '{"beq_mis",  1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100,      32'h2,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[13] = '{"bubble",   1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h100,      32'h20,       32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[14] = '{"jal_prio", 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h1000,     32'h100,      32'h0,        1'b0, 1'b0, 1'b1, 32'h1100,     1'b0, 1'b0};
    vecs[15] = '{"jalr_pri", 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0,        32'h11,       32'h1000,     1'b0, 1'b0, 1'b1, 32'h1010,     1'b0, 1'b0};
    vecs[16] = '{"bltu_t",   1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'h20,       32'h20,       32'h0,        1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 1'b0};
    vecs[17] = '{"bge_t",    1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 32'h0,        32'hC,        32'h0,        1'b0, 1'b0, 1'b1, 32'hC,        1'b0, 1'b0};

    // Reset state; BrUn is combinational even while rst is high.
    rst = 1'b1;
    bubble();
    ex_funct3 = 3'b010;
    #1;
    chk("brun_in_rst", {31'd0, BrUn}, 32'd1);
    tick(); tick();
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    chk("rst_flush", {30'd0, flush_if, flush_id}, 32'd0);
    chk("rst_exc", {30'd0, illegal_branch, misaligned_target}, 32'd0);
    rst = 1'b0;
    bubble();
    tick();

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, 1'b0, vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].f3,
            vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].eq, vecs[i].lt);
      #1;
      chk({vecs[i].name, ".brun"}, {31'd0, BrUn}, {31'd0, vecs[i].f3[1]});
      tick();
      bubble();
      chk({vecs[i].name, ".redir"}, {31'd0, redirect_valid}, {31'd0, vecs[i].exp_rd});
      if (vecs[i].exp_rd) chk({vecs[i].name, ".pc"}, redirect_pc, vecs[i].exp_pc);
      chk({vecs[i].name, ".ill"}, {31'd0, illegal_branch}, {31'd0, vecs[i].exp_ill});
      chk({vecs[i].name, ".mis"}, {31'd0, misaligned_target}, {31'd0, vecs[i].exp_mis});
      chk({vecs[i].name, ".flush1"}, {30'd0, flush_if, flush_id}, {30'd0, vecs[i].exp_rd, vecs[i].exp_rd});
      tick();
      chk({vecs[i].name, ".pulse"}, {29'd0, redirect_valid, illegal_branch, misaligned_target}, 32'd0);
      chk({vecs[i].name, ".flush2"}, {31'd0, flush_if}, {31'd0, vecs[i].exp_rd});
      tick();
      chk({vecs[i].name, ".flush3"}, {30'd0, flush_if, flush_id}, 32'd0);
    end

    // Wrong-path BNE during FLUSH is squashed; back-to-back branch afterwards is accepted.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h400, 32'h10, 32'h0, 1'b0, 1'b0);
    tick();
    chk("sq.redir", {31'd0, redirect_valid}, 32'd1);
    chk("sq.pc", redirect_pc, 32'h410);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h500, 32'h40, 32'h0, 1'b0, 1'b0);
    #1;
    chk("sq.squash", {31'd0, ex_squash}, 32'd1);
    tick();
    bubble();
    chk("sq.no_redir", {31'd0, redirect_valid}, 32'd0);
    chk("sq.flush", {31'd0, flush_if}, 32'd1);
    tick();
    chk("sq.no_redir2", {31'd0, redirect_valid}, 32'd0);
    chk("sq.flush_off", {31'd0, flush_if}, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h600, 32'h8, 32'h0, 1'b1, 1'b0);
    #1;
    chk("b2b.no_squash", {31'd0, ex_squash}, 32'd0);
    tick();
    bubble();
    chk("b2b.redir", {31'd0, redirect_valid}, 32'd1);
    chk("b2b.pc", redirect_pc, 32'h608);
    tick(); tick();

    // Three stall cycles inside FLUSH stretch the flush window to five cycles.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h700, 32'h20, 32'h0, 1'b0, 1'b0);
    tick();
    bubble();
    begin
      int nf_if = 0;
      int nf_id = 0;
      for (int c = 0; c < 10; c++) begin
        if (flush_if) nf_if++;
        if (flush_id) nf_id++;
        ex_stall = (c < 3);
        tick();
      end
      chk("stall.flush_if_len", nf_if, 32'd5);
      chk("stall.flush_id_len", nf_id, 32'd5);
    end
    bubble();

    // Stall in IDLE: the held branch resolves once on the first free cycle.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h800, 32'h4, 32'h0, 1'b1, 1'b0);
    tick();
    chk("istall.hold1", {31'd0, redirect_valid}, 32'd0);
    tick();
    chk("istall.hold2", {31'd0, redirect_valid}, 32'd0);
    ex_stall = 1'b0;
    tick();
    bubble();
    chk("istall.redir", {31'd0, redirect_valid}, 32'd1);
    chk("istall.pc", redirect_pc, 32'h804);
    tick();
    chk("istall.once", {31'd0, redirect_valid}, 32'd0);
    tick(); tick();

    // Reset in the middle of FLUSH clears everything on the next cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h900, 32'h40, 32'h0, 1'b0, 1'b0);
    tick();
    bubble();
    chk("mrst.flush_pre", {31'd0, flush_if}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mrst.flush", {30'd0, flush_if, flush_id}, 32'd0);
    chk("mrst.redir", {31'd0, redirect_valid}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'hA00, 32'h10, 32'h0, 1'b1, 1'b0);
    #1;
    chk("mrst.idle", {31'd0, ex_squash}, 32'd0);
    tick();
    bubble();
    chk("mrst.redir_after", redirect_pc, 32'hA10);
    tick(); tick();

`ifdef BRANCH_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'h0, (k < 3), 1'b0);
      tick();
      bubble();
      tick(); tick();
    end
    chk("perf.branch", perf_branch_cnt, 32'd5);
    chk("perf.taken", perf_taken_cnt, 32'd3);
`else
    chk("perf.branch_off", perf_branch_cnt, 32'd0);
    chk("perf.taken_off", perf_taken_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the branch comparator's BrEq/BrLT flags.
- Drives BrUn back to the comparator from funct3.
- Decides the branch/jump outcome and computes the target.
- Issues a registered PC redirect plus a multi-cycle IF/ID flush under static not-taken prediction; wrong-path instructions arriving in EX during the flush window are squashed.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_if/flush_id stay asserted after a redirect (legal range 1..7).
- XLEN, 32, datapath width of PC, immediate and rs1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ex_valid  input  1  EX stage holds a valid instruction.
- ex_stall  input  1  EX frozen this cycle; no resolution, FSM counter holds.
- ex_is_branch  input  1  conditional branch (B-type).
- ex_is_jal  input  1  JAL.
- ex_is_jalr  input  1  JALR.
- ex_funct3  input  3  branch condition code.
- ex_pc  input  XLEN  PC of the EX instruction.
- ex_imm  input  XLEN  sign-extended immediate.
- ex_rs1  input  XLEN  rs1 operand, used for JALR.
- BrEq  input  1  comparator equal flag.
- BrLT  input  1  comparator less-than flag.
- BrUn  output  1  comparator unsigned select; combinational, equals ex_funct3[1].
- redirect_valid  output  1  one-cycle pulse: fetch loads redirect_pc.
- redirect_pc  output  XLEN  registered target address.
- flush_if  output  1  kill IF/ID register contents.
- flush_id  output  1  kill ID/EX register contents.
- ex_squash  output  1  combinational; current EX instruction is wrong-path and must not retire.
- illegal_branch  output  1  registered one-cycle pulse; funct3 010/011 on a branch.
- misaligned_target  output  1  registered one-cycle pulse; taken target with bit 1 set.

Behaviour:
- Reset values: all registered outputs 0, FSM in IDLE, flush counter 0. BrUn follows ex_funct3[1] even during reset.
- Resolve condition: ex_valid & !ex_stall & state==IDLE.
- Flag priority: ex_is_jalr > ex_is_jal > ex_is_branch.
- Taken decode by funct3:
  - 000: BrEq
  - 001: !BrEq
  - 100: BrLT
  - 101: !BrLT
  - 110: BrLT (unsigned via BrUn)
  - 111: !BrLT
  - 010/011: not taken; illegal_branch pulses in cycle N+1.
- Targets:
  - Branch and JAL: ex_pc + ex_imm.
  - JALR: (ex_rs1 + ex_imm) with bit 0 cleared.
  - All additions are modulo 2^XLEN; wrap-around is not an error.
- Taken with target[1]==1:
  - No redirect and no flush.
  - misaligned_target pulses in cycle N+1.
  - FSM stays IDLE.
- Taken with aligned target, resolved in cycle N:
  - Cycle N+1: redirect_valid=1 for exactly one cycle, redirect_pc=target.
  - flush_if and flush_id high from N+1 for FLUSH_CYCLES cycles.
  - FSM goes IDLE -> FLUSH.
- Not taken: no outputs change (prediction correct).
- FSM IDLE:
  - Goes to FLUSH on an aligned taken resolve.
  - Loads the counter with FLUSH_CYCLES.
- FSM FLUSH:
  - Counter decrements each cycle with ex_stall=0 and holds while ex_stall=1.
  - On the cycle the counter reaches 1 and decrements, return to IDLE; flushes deassert the following cycle.
- During FLUSH:
  - ex_squash = ex_valid.
  - No resolution occurs, so a taken branch in the wrong path is ignored.
- ex_stall during IDLE: nothing resolves. The same instruction resolves on the first unstalled cycle, exactly once.
- Back-to-back: a taken branch on the first IDLE cycle after FLUSH is accepted normally.
- rst mid-FLUSH: next cycle IDLE, all flush and redirect outputs 0.
- No ex_valid (bubble): no action, regardless of flag inputs.

Optional Feature:
- Macro BRANCH_PERF_CNT_EN.
- Defined:
  - Adds 32-bit registers perf_branch_cnt (resolved conditional branches, legal funct3 only) and perf_taken_cnt (those taken and redirected), both driven on output ports of the same names.
  - Registers clear on rst and wrap 0xFFFFFFFF -> 0.
  - Squashed instructions are never counted.
- Undefined: same ports exist, tied to 0, and no counter flops are inferred.

Test Plan:
- BEQ, ex_pc=0x100, ex_imm=0x20, BrEq=1:
  - N+1: redirect_valid=1, redirect_pc=0x120.
  - flush_if/flush_id high for 2 cycles, then 0.
- BLTU, funct3=110, BrLT=0 -> BrUn=1, no redirect, no flush, FSM stays IDLE.
- JALR, ex_rs1=0x203, ex_imm=0x4 -> redirect_pc=0x206 (target 0x207 with bit 0 cleared, bit 1 set) -> misaligned_target pulse, no redirect. Variant ex_rs1=0x201 -> target 0x204 (0x205 with bit 0 cleared), normal redirect to 0x204.
- Taken JAL, then a taken BNE arriving in the cycle after redirect:
  - BNE is squashed (ex_squash=1) and makes no second redirect.
  - ex_stall=1 for 3 cycles inside FLUSH extends flush assertion to 5 cycles.
- Branch funct3=010 -> illegal_branch pulse one cycle, no redirect. rst asserted during FLUSH -> all outputs 0 the next cycle.
- With BRANCH_PERF_CNT_EN:
  - 5 branches (3 taken) -> perf_branch_cnt=5, perf_taken_cnt=3.
  - Preloaded perf_taken_cnt of 0xFFFFFFFF plus one taken branch wraps to 0.
